// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer: issues a 16-bit operation to an 8-bit combinational ALU
// as two byte steps and chains the carry and zero flags between the steps.
// Optional build macro ALUSEQ_B2B_EN: accepts a new START in FIN so a new op
// can begin every 3 cycles instead of every 4.
//
// state | meaning
// IDLE  | waiting for START, ALU driven with idle values
// STEP0 | first byte (low byte, or high byte for LSR)
// STEP1 | second byte, carry/borrow/shift bit from STEP0 fed in as ALU carry-in
// FIN   | DONE pulse, RESULT/C/Z valid
module alu_wide_sequencer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [15:0] opa_i,
    input  logic [15:0] opb_i,
    input  logic        cin_i,
    output logic [7:0]  alu_a_o,
    output logic [7:0]  alu_b_o,
    output logic [3:0]  alu_sel_o,
    output logic        alu_cin_o,
    input  logic [7:0]  alu_result_i,
    input  logic        alu_c_i,
    input  logic        alu_z_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] result_o,
    output logic        c_o,
    output logic        z_o
);

    localparam logic [3:0] IDLE_SEL = 4'b1111;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LSL = 3'b101;
    localparam logic [2:0] OP_LSR = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STEP0 = 2'd1,
        S_STEP1 = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] opa_q, opa_d;
    logic [15:0] opb_q, opb_d;
    logic        cin_q, cin_d;
    logic [7:0]  byte_q, byte_d;
    logic        c0_q, c0_d;
    logic        z0_q, z0_d;
    logic [15:0] result_q, result_d;
    logic        c_q, c_d;
    logic        z_q, z_d;
    logic        accept;
    logic        hi_byte;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= 3'b000;
            opa_q    <= 16'h0000;
            opb_q    <= 16'h0000;
            cin_q    <= 1'b0;
            byte_q   <= 8'h00;
            c0_q     <= 1'b0;
            z0_q     <= 1'b0;
            result_q <= 16'h0000;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            cin_q    <= cin_d;
            byte_q   <= byte_d;
            c0_q     <= c0_d;
            z0_q     <= z0_d;
            result_q <= result_d;
            c_q      <= c_d;
            z_q      <= z_d;
        end
    end

    // Next-state logic: accept requests, capture per-step ALU response, assemble the word.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        cin_d    = cin_q;
        byte_d   = byte_q;
        c0_d     = c0_q;
        z0_d     = z0_q;
        result_d = result_q;
        c_d      = c_q;
        z_d      = z_q;
        accept   = 1'b0;
        case (state_q)
            S_IDLE: begin
                accept = start_i;
            end
            S_STEP0: begin
                byte_d  = alu_result_i;
                c0_d    = alu_c_i;
                z0_d    = alu_z_i;
                state_d = S_STEP1;
            end
            S_STEP1: begin
                c_d = alu_c_i;
                z_d = z0_q & alu_z_i;
                // LSR ran the high byte first, so the held byte is the upper half.
                if (op_q == OP_LSR) begin
                    result_d = {byte_q, alu_result_i};
                end else if (op_q != OP_CMP) begin
                    result_d = {alu_result_i, byte_q};
                end
                state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
`ifdef ALUSEQ_B2B_EN
                accept = start_i;
`else
                accept = 1'b0;
`endif
            end
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            op_d    = op_i;
            opa_d   = opa_i;
            opb_d   = opb_i;
            cin_d   = cin_i;
            state_d = S_STEP0;
        end
    end

    // ALU drive: byte select, function select and carry-in for the active step.
    always_comb begin
        alu_a_o   = 8'h00;
        alu_b_o   = 8'h00;
        alu_sel_o = IDLE_SEL;
        alu_cin_o = 1'b0;
        hi_byte   = (state_q == S_STEP1) ^ (op_q == OP_LSR);
        if (state_q == S_STEP0 || state_q == S_STEP1) begin
            alu_a_o = hi_byte ? opa_q[15:8] : opa_q[7:0];
            alu_b_o = hi_byte ? opb_q[15:8] : opb_q[7:0];
            if (state_q == S_STEP0) begin
                alu_cin_o = (op_q == OP_LSL || op_q == OP_LSR) ? cin_q : 1'b0;
            end else begin
                alu_cin_o = c0_q;
            end
            case (op_q)
                OP_ADD:  alu_sel_o = (state_q == S_STEP0) ? 4'b0000 : 4'b0001;
                OP_SUB:  alu_sel_o = (state_q == S_STEP0) ? 4'b0010 : 4'b0011;
                OP_CMP:  alu_sel_o = (state_q == S_STEP0) ? 4'b0100 : 4'b0011;
                OP_AND:  alu_sel_o = 4'b0101;
                OP_OR:   alu_sel_o = 4'b0110;
                OP_XOR:  alu_sel_o = 4'b0111;
                OP_LSL:  alu_sel_o = 4'b1001;
                OP_LSR:  alu_sel_o = 4'b1010;
                default: alu_sel_o = IDLE_SEL;
            endcase
        end
    end

    assign busy_o   = (state_q == S_STEP0) || (state_q == S_STEP1);
    assign done_o   = (state_q == S_FIN);
    assign result_o = result_q;
    assign c_o      = c_q;
    assign z_o      = z_q;

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Directed bench for alu_wide_sequencer with a behavioural model of the 8-bit ALU.
module tb_alu_wide_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [2:0]  op_i;
    logic [15:0] opa_i, opb_i;
    logic        cin_i;
    logic [7:0]  alu_a_o, alu_b_o;
    logic [3:0]  alu_sel_o;
    logic        alu_cin_o;
    logic [7:0]  alu_result_i;
    logic        alu_c_i, alu_z_i;
    logic        busy_o, done_o;
    logic [15:0] result_o;
    logic        c_o, z_o;

    int errors = 0;
    int checks = 0;

    alu_wide_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
        .opa_i(opa_i), .opb_i(opb_i), .cin_i(cin_i),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_sel_o(alu_sel_o), .alu_cin_o(alu_cin_o),
        .alu_result_i(alu_result_i), .alu_c_i(alu_c_i), .alu_z_i(alu_z_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .c_o(c_o), .z_o(z_o)
    );

    always #5 clk_i = ~clk_i;

    // 8-bit RAT ALU model: bit 8 of tmp is the carry/borrow/shifted-out bit.
    logic [8:0] tmp;
    always_comb begin
        tmp = 9'h000;
        case (alu_sel_o)
            4'b0000: tmp = {1'b0, alu_a_o} + {1'b0, alu_b_o};
            4'b0001: tmp = {1'b0, alu_a_o} + {1'b0, alu_b_o} + {8'h00, alu_cin_o};
            4'b0010: tmp = {1'b0, alu_a_o} - {1'b0, alu_b_o};
            4'b0011: tmp = {1'b0, alu_a_o} - {1'b0, alu_b_o} - {8'h00, alu_cin_o};
            4'b0100: tmp = {1'b0, alu_a_o} - {1'b0, alu_b_o};
            4'b0101: tmp = {1'b0, alu_a_o & alu_b_o};
            4'b0110: tmp = {1'b0, alu_a_o | alu_b_o};
            4'b0111: tmp = {1'b0, alu_a_o ^ alu_b_o};
            4'b1001: tmp = {alu_a_o, alu_cin_o};
            4'b1010: tmp = {alu_a_o[0], alu_cin_o, alu_a_o[7:1]};
            default: tmp = 9'h000;
        endcase
        alu_result_i = tmp[7:0];
        alu_c_i      = tmp[8];
        alu_z_i      = (tmp[7:0] == 8'h00);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Presents a request for one edge; returns in the first cycle after acceptance (STEP0).
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cin);
        op_i = op; opa_i = a; opb_i = b; cin_i = cin; start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done_o); end
        checks++; if ({result_o, c_o, z_o} !== 18'h0) begin errors++; $display("FAIL reset_result got=%h c=%b z=%b want=0000 0 0", result_o, c_o, z_o); end
        checks++; if ({alu_sel_o, alu_a_o, alu_b_o, alu_cin_o} !== {4'b1111, 17'h0}) begin errors++; $display("FAIL reset_alu_drive sel=%b a=%h b=%h cin=%b want 1111 00 00 0", alu_sel_o, alu_a_o, alu_b_o, alu_cin_o); end
    endtask

    task automatic test_add();
        issue(3'b000, 16'h00FF, 16'h0001, 1'b0);
        checks++; if ({busy_o, done_o, alu_sel_o, alu_a_o, alu_b_o, alu_cin_o} !== {1'b1, 1'b0, 4'b0000, 8'hFF, 8'h01, 1'b0}) begin errors++; $display("FAIL add_step0 busy=%b done=%b sel=%b a=%h b=%h cin=%b want 1 0 0000 ff 01 0", busy_o, done_o, alu_sel_o, alu_a_o, alu_b_o, alu_cin_o); end
        tick();
        checks++; if ({busy_o, done_o, alu_sel_o, alu_a_o, alu_cin_o} !== {1'b1, 1'b0, 4'b0001, 8'h00, 1'b1}) begin errors++; $display("FAIL add_step1 busy=%b done=%b sel=%b a=%h cin=%b want 1 0 0001 00 1", busy_o, done_o, alu_sel_o, alu_a_o, alu_cin_o); end
        tick();
        checks++; if ({busy_o, done_o} !== 2'b01) begin errors++; $display("FAIL add_fin busy=%b done=%b want 0 1", busy_o, done_o); end
        checks++; if ({result_o, c_o, z_o} !== {16'h0100, 1'b0, 1'b0}) begin errors++; $display("FAIL add_result got=%h c=%b z=%b want 0100 0 0", result_o, c_o, z_o); end
        checks++; if (alu_sel_o !== 4'b1111) begin errors++; $display("FAIL add_fin_sel got=%b want 1111", alu_sel_o); end
        tick();
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL add_done_pulse got=%b want 0", done_o); end
    endtask

    task automatic test_sub();
        issue(3'b001, 16'h0000, 16'h0001, 1'b0);
        checks++; if (alu_sel_o !== 4'b0010) begin errors++; $display("FAIL sub_sel0 got=%b want 0010", alu_sel_o); end
        tick();
        checks++; if ({alu_sel_o, alu_cin_o} !== {4'b0011, 1'b1}) begin errors++; $display("FAIL sub_sel1 sel=%b cin=%b want 0011 1", alu_sel_o, alu_cin_o); end
        tick();
        checks++; if ({done_o, result_o, c_o, z_o} !== {1'b1, 16'hFFFF, 1'b1, 1'b0}) begin errors++; $display("FAIL sub_result done=%b got=%h c=%b z=%b want 1 ffff 1 0", done_o, result_o, c_o, z_o); end
        tick();
    endtask

    task automatic test_cmp();
        issue(3'b000, 16'h00FF, 16'h0001, 1'b0);
        tick(); tick(); tick();
        issue(3'b111, 16'h1234, 16'h1234, 1'b0);
        checks++; if (alu_sel_o !== 4'b0100) begin errors++; $display("FAIL cmp_sel0 got=%b want 0100", alu_sel_o); end
        tick();
        checks++; if (alu_sel_o !== 4'b0011) begin errors++; $display("FAIL cmp_sel1 got=%b want 0011", alu_sel_o); end
        tick();
        checks++; if ({done_o, result_o, c_o, z_o} !== {1'b1, 16'h0100, 1'b0, 1'b1}) begin errors++; $display("FAIL cmp_result done=%b got=%h c=%b z=%b want 1 0100 0 1", done_o, result_o, c_o, z_o); end
        tick();
    endtask

    task automatic test_shifts();
        issue(3'b110, 16'h0001, 16'h0000, 1'b1);
        checks++; if ({alu_sel_o, alu_a_o, alu_cin_o} !== {4'b1010, 8'h00, 1'b1}) begin errors++; $display("FAIL lsr_step0 sel=%b a=%h cin=%b want 1010 00 1", alu_sel_o, alu_a_o, alu_cin_o); end
        tick();
        checks++; if ({alu_sel_o, alu_a_o, alu_cin_o} !== {4'b1010, 8'h01, 1'b0}) begin errors++; $display("FAIL lsr_step1 sel=%b a=%h cin=%b want 1010 01 0", alu_sel_o, alu_a_o, alu_cin_o); end
        tick();
        checks++; if ({done_o, result_o, c_o, z_o} !== {1'b1, 16'h8000, 1'b1, 1'b0}) begin errors++; $display("FAIL lsr_result done=%b got=%h c=%b z=%b want 1 8000 1 0", done_o, result_o, c_o, z_o); end
        tick();
        issue(3'b101, 16'h8000, 16'h0000, 1'b0);
        checks++; if ({alu_sel_o, alu_a_o} !== {4'b1001, 8'h00}) begin errors++; $display("FAIL lsl_step0 sel=%b a=%h want 1001 00", alu_sel_o, alu_a_o); end
        tick(); tick();
        checks++; if ({done_o, result_o, c_o, z_o} !== {1'b1, 16'h0000, 1'b1, 1'b1}) begin errors++; $display("FAIL lsl_result done=%b got=%h c=%b z=%b want 1 0000 1 1", done_o, result_o, c_o, z_o); end
        tick();
    endtask

    task automatic test_logic();
        issue(3'b010, 16'hF0F0, 16'h0FF0, 1'b1);
        checks++; if ({alu_sel_o, alu_cin_o} !== {4'b0101, 1'b0}) begin errors++; $display("FAIL and_step0 sel=%b cin=%b want 0101 0", alu_sel_o, alu_cin_o); end
        tick(); tick();
        checks++; if ({done_o, result_o, c_o, z_o} !== {1'b1, 16'h00F0, 1'b0, 1'b0}) begin errors++; $display("FAIL and_result done=%b got=%h c=%b z=%b want 1 00f0 0 0", done_o, result_o, c_o, z_o); end
        tick();
        issue(3'b100, 16'hA55A, 16'hA55A, 1'b0);
        checks++; if (alu_sel_o !== 4'b0111) begin errors++; $display("FAIL xor_sel got=%b want 0111", alu_sel_o); end
        tick(); tick();
        checks++; if ({done_o, result_o, c_o, z_o} !== {1'b1, 16'h0000, 1'b0, 1'b1}) begin errors++; $display("FAIL xor_result done=%b got=%h c=%b z=%b want 1 0000 0 1", done_o, result_o, c_o, z_o); end
        tick();
        issue(3'b011, 16'h1200, 16'h0034, 1'b0);
        tick(); tick();
        checks++; if ({done_o, result_o, c_o, z_o} !== {1'b1, 16'h1234, 1'b0, 1'b0}) begin errors++; $display("FAIL or_result done=%b got=%h c=%b z=%b want 1 1234 0 0", done_o, result_o, c_o, z_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        issue(3'b000, 16'h1234, 16'h1111, 1'b0);
        tick(); tick(); tick();
        checks++; if (result_o !== 16'h2345) begin errors++; $display("FAIL pre_reset_result got=%h want 2345", result_o); end
        issue(3'b000, 16'h1234, 16'h1111, 1'b0);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checks++; if ({done_o, busy_o, result_o, c_o, z_o, alu_sel_o} !== {2'b00, 16'h0000, 2'b00, 4'b1111}) begin errors++; $display("FAIL mid_reset done=%b busy=%b got=%h c=%b z=%b sel=%b want 0 0 0000 0 0 1111", done_o, busy_o, result_o, c_o, z_o, alu_sel_o); end
        tick();
        checks++; if ({done_o, busy_o} !== 2'b00) begin errors++; $display("FAIL mid_reset_after done=%b busy=%b want 0 0", done_o, busy_o); end
    endtask

    task automatic test_back_to_back();
        int first_t = -1;
        int second_t = -1;
        logic [15:0] r1 = 16'hxxxx;
        logic [15:0] r2 = 16'hxxxx;
        int exp_gap;
`ifdef ALUSEQ_B2B_EN
        exp_gap = 3;
`else
        exp_gap = 4;
`endif
        op_i = 3'b000; opa_i = 16'h0001; opb_i = 16'h0001; cin_i = 1'b0; start_i = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 1) opa_i = 16'h0002;
            if (done_o === 1'b1) begin
                if (first_t < 0) begin
                    first_t = i; r1 = result_o;
                end else if (second_t < 0) begin
                    second_t = i; r2 = result_o; start_i = 1'b0;
                end
            end
        end
        start_i = 1'b0;
        checks++; if (first_t !== 3) begin errors++; $display("FAIL b2b_first_done got=%0d want 3", first_t); end
        checks++; if (second_t - first_t !== exp_gap) begin errors++; $display("FAIL b2b_gap got=%0d want %0d", second_t - first_t, exp_gap); end
        checks++; if ({r1, r2} !== {16'h0002, 16'h0003}) begin errors++; $display("FAIL b2b_results got=%h,%h want 0002,0003", r1, r2); end
        tick(); tick(); tick(); tick();
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; op_i = 3'b000; opa_i = 16'h0; opb_i = 16'h0; cin_i = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_cmp();
        test_shifts();
        test_logic();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
